instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding the IR consumed by register select/encode logic (IRotp) and the control unit.
//  Holds the PC and issues one word-read per instruction to memory with a ready handshake.
//  Latches the returned word into IR and holds it until the control unit acknowledges retirement.
//  Supports branch/jump PC load with squash of an in-flight fetch, halt, and a fetch-timeout error.
// PARAMETERS
//  ADDR_W     9    memory word-address width; PC width
//  DATA_W     32   instruction/memory data width
//  RESET_PC   0    PC value after reset
//  TIMEOUT    15   max cycles waiting for mem_ready before fetch_err (1..255)
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  clr          in   1       reset, asynchronous, active-high
//  halt         in   1       level; blocks issue of new fetches
//  mem_rd       out  1       read strobe, held high until mem_ready
//  mem_addr     out  ADDR_W  read address (= PC of the fetch in flight)
//  mem_rdata    in   DATA_W  read data, valid when mem_ready=1
//  mem_ready    in   1       read completion, 1-cycle pulse
//  ir_out       out  DATA_W  instruction register (to IRotp of select/encode logic)
//  ir_valid     out  1       ir_out holds an unretired instruction
//  ir_ack       in   1       control unit retires ir_out; ignored unless ir_valid
//  pc_load      in   1       redirect PC to pc_load_val
//  pc_load_val  in   ADDR_W  redirect target
//  pc_out       out  ADDR_W  current PC (address of next fetch)
//  fetch_err    out  1       sticky; set on timeout, cleared only by clr
// BEHAVIOUR
//  Reset (async, clr=1): state=IDLE, pc_out=RESET_PC, ir_out=0, ir_valid=0, mem_rd=0,
//   mem_addr=RESET_PC, fetch_err=0, wait counter=0. Outputs hold reset values while clr=1.
//  FSM states: IDLE, REQ, WAIT, HOLD, ERR.
//   IDLE: if !halt -> REQ. pc_load in IDLE updates PC, stays IDLE that cycle.
//   REQ:  mem_rd=1, mem_addr=pc_out; -> WAIT next cycle (one-cycle issue).
//   WAIT: mem_rd=1. On mem_ready: ir_out<=mem_rdata, ir_valid<=1, pc_out<=pc_out+1, -> HOLD.
//         Counter increments each WAIT cycle; reaching TIMEOUT without mem_ready: fetch_err<=1, -> ERR.
//   HOLD: ir_valid=1, ir_out stable. On ir_ack: ir_valid<=0; -> REQ if !halt else IDLE.
//   ERR:  mem_rd=0, ir_valid=0; terminal until clr.
//  Latency: ir_ack at cycle n with zero-wait memory (mem_ready in first WAIT cycle)
//   -> REQ n+1, WAIT n+2, ir_valid=1 at n+3. Min 3 cycles ack-to-valid.
//  PC arithmetic: ADDR_W-bit unsigned, wraps 2^ADDR_W-1 -> 0, no flag.
//  pc_load priority (over increment, every state except ERR):
//   HOLD: pc_out<=pc_load_val; ir_out unaffected; effective for next fetch.
//   REQ/WAIT: fetch squashed; pc_out<=pc_load_val; returning data discarded, ir_valid stays 0;
//    -> REQ next cycle (same-cycle mem_ready with pc_load is also discarded).
//   Simultaneous ir_ack and pc_load in HOLD: retire and redirect; next REQ uses pc_load_val.
//  halt: only checked at IDLE exit and HOLD->next; an in-flight fetch always completes.
//  mem_ready outside WAIT: ignored.
//  mem_addr changes only on entry to REQ; stable through WAIT.
// STRUCTURE
//  Shared pkg risc_pkg: fetch_state_t enum {IDLE,REQ,WAIT,HOLD,ERR}; IR field constants
//   OPC_MSB=31/OPC_LSB=27, RA 26:23, RB 22:19, RC 18:15, C 18:0 (shared with select/encode).
//  Sub-module pc_counter: PC reg with async clr to RESET_PC, load (priority) and increment, wrap.
//  Remainder (FSM, IR latch, wait counter, sticky error) in instr_fetch_unit.
// TESTING
//  1. clr pulse mid-WAIT -> all outputs return to reset values immediately; fetch restarts at PC 0.
//  2. mem returns 32'h0A200007 at addr 0 on first WAIT cycle -> ir_out=0A200007, ir_valid=1 on
//     cycle 3, pc_out=1; hold 5 cycles no ack -> ir_out unchanged; ack -> next mem_addr=1.
//  3. PC=9'h1FF fetch completes -> pc_out=0; next mem_addr=0.
//  4. pc_load=1, val=9'h040 during WAIT, mem_ready same cycle -> data discarded, ir_valid=0,
//     next REQ mem_addr=040.
//  5. mem_ready never asserted -> fetch_err=1 after 15 WAIT cycles, mem_rd=0, stays until clr.
//  6. halt=1 with ir_ack in HOLD -> IDLE, mem_rd=0; halt=0 -> REQ next cycle at current PC.

Source files
------------

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared fetch state encoding and IR field positions
package risc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } fetch_state_t;

  // IR field positions, shared with the register select/encode logic
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;
  localparam int C_MSB   = 18;
  localparam int C_LSB   = 0;

  localparam int WAIT_CNT_W = 8;

  // Last wait-counter value before a fetch is declared timed out
  function automatic logic [WAIT_CNT_W-1:0] wait_cnt_last(input int timeout);
    return WAIT_CNT_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory read bus
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Fetch unit side: issues reads
  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  // Memory side: answers reads
  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/instr_fetch_unit_pc_counter.sv
// rtl/instr_fetch_unit_pc_counter.sv - program counter with priority load and wrapping increment
module pc_counter #(
  parameter int                ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Load wins over increment; increment wraps naturally at 2^ADDR_W
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc      = pc_q;
  assign pc_next = pc_d;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, memory read handshake, IR latch, timeout error
module instr_fetch_unit
  import risc_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                halt,
  instr_fetch_unit_if.master  mem,
  output logic [DATA_W-1:0]   ir_out,
  output logic                ir_valid,
  input  logic                ir_ack,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_load_val,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                fetch_err
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LAST = wait_cnt_last(TIMEOUT);

  fetch_state_t state_q, state_d;

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]     ir_q, ir_d;
  logic                  ir_valid_q, ir_valid_d;
  logic                  err_q, err_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  mem_rd_o;

  logic                  pc_ld;
  logic                  pc_inc;
  logic [ADDR_W-1:0]     pc_cur;
  logic [ADDR_W-1:0]     pc_next;
  logic                  ready_hit;

  // A returning word is accepted only in WAIT and only if no redirect squashes it
  assign ready_hit = (state_q == WAIT) && mem.mem_ready && !pc_load;
  assign pc_ld     = pc_load && (state_q != ERR);
  assign pc_inc    = ready_hit;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (ADDR_W'(RESET_PC))
  ) u_pc (
    .clk      (clk),
    .clr      (clr),
    .load     (pc_ld),
    .inc      (pc_inc),
    .load_val (pc_load_val),
    .pc       (pc_cur),
    .pc_next  (pc_next)
  );

  // FSM state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: redirects restart the fetch, halt only gates new issues
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!pc_load && !halt) state_d = REQ;
      REQ:  state_d = pc_load ? REQ : WAIT;
      WAIT: begin
        if (pc_load) begin
          state_d = REQ;
        end else if (mem.mem_ready) begin
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
        end
      end
      HOLD: if (ir_ack) state_d = halt ? IDLE : REQ;
      ERR:  state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: read strobe held from issue until completion
  always_comb begin
    mem_rd_o = (state_q == REQ) || (state_q == WAIT);
  end

  // Datapath next values: address latch on REQ entry, wait counter, IR, valid, sticky error
  always_comb begin
    mem_addr_d = (state_d == REQ) ? pc_next : mem_addr_q;
    cnt_d      = ((state_q == WAIT) && (state_d == WAIT)) ? cnt_q + WAIT_CNT_W'(1) : '0;
    ir_d       = ready_hit ? mem.mem_rdata : ir_q;
    ir_valid_d = ir_valid_q;
    if (ready_hit) begin
      ir_valid_d = 1'b1;
    end else if ((state_q == HOLD) && ir_ack) begin
      ir_valid_d = 1'b0;
    end
    err_d = err_q || ((state_q == WAIT) && (state_d == ERR));
  end

  // Datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mem_addr_q <= ADDR_W'(RESET_PC);
      cnt_q      <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      err_q      <= err_d;
    end
  end

  assign mem.mem_rd   = mem_rd_o;
  assign mem.mem_addr = mem_addr_q;
  assign ir_out       = ir_q;
  assign ir_valid     = ir_valid_q;
  assign pc_out       = pc_cur;
  assign fetch_err    = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        halt;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_ack;
  logic        pc_load;
  logic [8:0]  pc_load_val;
  logic [8:0]  pc_out;
  logic        fetch_err;

  int tests_run    = 0;
  int tests_failed = 0;

  instr_fetch_unit_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (9),
    .DATA_W   (32),
    .RESET_PC (0),
    .TIMEOUT  (15)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .halt        (halt),
    .mem         (bus),
    .ir_out      (ir_out),
    .ir_valid    (ir_valid),
    .ir_ack      (ir_ack),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .pc_out      (pc_out),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From REQ: step into WAIT, answer on the first WAIT cycle, land in HOLD
  task automatic complete_fetch(input logic [31:0] data);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = data;
    tick();
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++; if (pc_out !== 9'h000) begin tests_failed++; $display("FAIL reset_pc got %h exp 000", pc_out); end
    tests_run++; if (ir_out !== 32'h0) begin tests_failed++; $display("FAIL reset_ir got %h exp 0", ir_out); end
    tests_run++; if (ir_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ir_valid got %b exp 0", ir_valid); end
    tests_run++; if (bus.mem_rd !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_rd got %b exp 0", bus.mem_rd); end
    tests_run++; if (bus.mem_addr !== 9'h000) begin tests_failed++; $display("FAIL reset_mem_addr got %h exp 000", bus.mem_addr); end
    tests_run++; if (fetch_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b exp 0", fetch_err); end
    tick();
    clr = 1'b0;
    tick();
    tests_run++; if (bus.mem_rd !== 1'b0) begin tests_failed++; $display("FAIL halted_idle_mem_rd got %b exp 0", bus.mem_rd); end
  endtask

  task automatic test_fetch();
    halt = 1'b0;
    tick();
    tests_run++; if (bus.mem_rd !== 1'b1) begin tests_failed++; $display("FAIL fetch_req_rd got %b exp 1", bus.mem_rd); end
    tests_run++; if (bus.mem_addr !== 9'h000) begin tests_failed++; $display("FAIL fetch_req_addr got %h exp 000", bus.mem_addr); end
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0A200007;
    tests_run++; if (bus.mem_rd !== 1'b1) begin tests_failed++; $display("FAIL fetch_wait_rd got %b exp 1", bus.mem_rd); end
    tests_run++; if (ir_valid !== 1'b0) begin tests_failed++; $display("FAIL fetch_wait_valid got %b exp 0", ir_valid); end
    tick();
    bus.mem_ready = 1'b0;
    tests_run++; if (ir_valid !== 1'b1) begin tests_failed++; $display("FAIL fetch_valid got %b exp 1", ir_valid); end
    tests_run++; if (ir_out !== 32'h0A200007) begin tests_failed++; $display("FAIL fetch_ir got %h exp 0a200007", ir_out); end
    tests_run++; if (pc_out !== 9'h001) begin tests_failed++; $display("FAIL fetch_pc got %h exp 001", pc_out); end
    tests_run++; if (bus.mem_rd !== 1'b0) begin tests_failed++; $display("FAIL fetch_hold_rd got %b exp 0", bus.mem_rd); end
    bus.mem_rdata = 32'hFFFFFFFF;
    repeat (5) tick();
    tests_run++; if (ir_out !== 32'h0A200007) begin tests_failed++; $display("FAIL hold_ir got %h exp 0a200007", ir_out); end
    tests_run++; if (ir_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_valid got %b exp 1", ir_valid); end
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    tests_run++; if (ir_valid !== 1'b0) begin tests_failed++; $display("FAIL ack_valid got %b exp 0", ir_valid); end
    tests_run++; if (bus.mem_addr !== 9'h001) begin tests_failed++; $display("FAIL ack_next_addr got %h exp 001", bus.mem_addr); end
    complete_fetch(32'h12345678);
    tests_run++; if (pc_out !== 9'h002) begin tests_failed++; $display("FAIL second_pc got %h exp 002", pc_out); end
  endtask

  task automatic test_wrap();
    pc_load     = 1'b1;
    pc_load_val = 9'h1FF;
    ir_ack      = 1'b1;
    tick();
    pc_load = 1'b0;
    ir_ack  = 1'b0;
    tests_run++; if (bus.mem_addr !== 9'h1FF) begin tests_failed++; $display("FAIL redirect_addr got %h exp 1ff", bus.mem_addr); end
    complete_fetch(32'h11111111);
    tests_run++; if (pc_out !== 9'h000) begin tests_failed++; $display("FAIL wrap_pc got %h exp 000", pc_out); end
    tests_run++; if (ir_out !== 32'h11111111) begin tests_failed++; $display("FAIL wrap_ir got %h exp 11111111", ir_out); end
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    tests_run++; if (bus.mem_addr !== 9'h000) begin tests_failed++; $display("FAIL wrap_next_addr got %h exp 000", bus.mem_addr); end
    complete_fetch(32'h22222222);
    tests_run++; if (pc_out !== 9'h001) begin tests_failed++; $display("FAIL after_wrap_pc got %h exp 001", pc_out); end
  endtask

  task automatic test_squash();
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    tick();
    tests_run++; if (bus.mem_addr !== 9'h001) begin tests_failed++; $display("FAIL wait_addr_stable got %h exp 001", bus.mem_addr); end
    pc_load       = 1'b1;
    pc_load_val   = 9'h040;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    tick();
    pc_load       = 1'b0;
    bus.mem_ready = 1'b0;
    tests_run++; if (ir_valid !== 1'b0) begin tests_failed++; $display("FAIL squash_valid got %b exp 0", ir_valid); end
    tests_run++; if (ir_out !== 32'h22222222) begin tests_failed++; $display("FAIL squash_ir got %h exp 22222222", ir_out); end
    tests_run++; if (bus.mem_addr !== 9'h040) begin tests_failed++; $display("FAIL squash_addr got %h exp 040", bus.mem_addr); end
    tests_run++; if (bus.mem_rd !== 1'b1) begin tests_failed++; $display("FAIL squash_rd got %b exp 1", bus.mem_rd); end
    tests_run++; if (pc_out !== 9'h040) begin tests_failed++; $display("FAIL squash_pc got %h exp 040", pc_out); end
    complete_fetch(32'h33333333);
    tests_run++; if (ir_out !== 32'h33333333) begin tests_failed++; $display("FAIL refetch_ir got %h exp 33333333", ir_out); end
    tests_run++; if (pc_out !== 9'h041) begin tests_failed++; $display("FAIL refetch_pc got %h exp 041", pc_out); end
  endtask

  task automatic test_halt();
    halt   = 1'b1;
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    tests_run++; if (bus.mem_rd !== 1'b0) begin tests_failed++; $display("FAIL halt_rd got %b exp 0", bus.mem_rd); end
    tests_run++; if (ir_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_valid got %b exp 0", ir_valid); end
    repeat (3) tick();
    tests_run++; if (bus.mem_rd !== 1'b0) begin tests_failed++; $display("FAIL halt_hold_rd got %b exp 0", bus.mem_rd); end
    tests_run++; if (pc_out !== 9'h041) begin tests_failed++; $display("FAIL halt_pc got %h exp 041", pc_out); end
    halt = 1'b0;
    tick();
    tests_run++; if (bus.mem_rd !== 1'b1) begin tests_failed++; $display("FAIL unhalt_rd got %b exp 1", bus.mem_rd); end
    tests_run++; if (bus.mem_addr !== 9'h041) begin tests_failed++; $display("FAIL unhalt_addr got %h exp 041", bus.mem_addr); end
    tick();
  endtask

  task automatic test_clr_mid_wait();
    tests_run++; if (bus.mem_rd !== 1'b1) begin tests_failed++; $display("FAIL pre_clr_rd got %b exp 1", bus.mem_rd); end
    clr = 1'b1;
    #1;
    tests_run++; if (pc_out !== 9'h000) begin tests_failed++; $display("FAIL clr_pc got %h exp 000", pc_out); end
    tests_run++; if (bus.mem_addr !== 9'h000) begin tests_failed++; $display("FAIL clr_addr got %h exp 000", bus.mem_addr); end
    tests_run++; if (bus.mem_rd !== 1'b0) begin tests_failed++; $display("FAIL clr_rd got %b exp 0", bus.mem_rd); end
    tests_run++; if (ir_out !== 32'h0) begin tests_failed++; $display("FAIL clr_ir got %h exp 0", ir_out); end
    tests_run++; if (ir_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_valid got %b exp 0", ir_valid); end
    tick();
    clr = 1'b0;
    tick();
    tests_run++; if (bus.mem_rd !== 1'b1) begin tests_failed++; $display("FAIL restart_rd got %b exp 1", bus.mem_rd); end
    tests_run++; if (bus.mem_addr !== 9'h000) begin tests_failed++; $display("FAIL restart_addr got %h exp 000", bus.mem_addr); end
  endtask

  task automatic test_timeout();
    tick();
    repeat (14) tick();
    tests_run++; if (fetch_err !== 1'b0) begin tests_failed++; $display("FAIL early_err got %b exp 0", fetch_err); end
    tests_run++; if (bus.mem_rd !== 1'b1) begin tests_failed++; $display("FAIL wait15_rd got %b exp 1", bus.mem_rd); end
    tick();
    tests_run++; if (fetch_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_err got %b exp 1", fetch_err); end
    tests_run++; if (bus.mem_rd !== 1'b0) begin tests_failed++; $display("FAIL timeout_rd got %b exp 0", bus.mem_rd); end
    pc_load       = 1'b1;
    pc_load_val   = 9'h0AA;
    ir_ack        = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (3) tick();
    pc_load       = 1'b0;
    ir_ack        = 1'b0;
    bus.mem_ready = 1'b0;
    tests_run++; if (fetch_err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky got %b exp 1", fetch_err); end
    tests_run++; if (bus.mem_rd !== 1'b0) begin tests_failed++; $display("FAIL err_rd got %b exp 0", bus.mem_rd); end
    tests_run++; if (ir_valid !== 1'b0) begin tests_failed++; $display("FAIL err_valid got %b exp 0", ir_valid); end
    tests_run++; if (pc_out !== 9'h000) begin tests_failed++; $display("FAIL err_pc_load_ignored got %h exp 000", pc_out); end
    clr = 1'b1;
    #1;
    tests_run++; if (fetch_err !== 1'b0) begin tests_failed++; $display("FAIL err_clear got %b exp 0", fetch_err); end
    tick();
    clr = 1'b0;
  endtask

  initial begin
    clr           = 1'b1;
    halt          = 1'b1;
    ir_ack        = 1'b0;
    pc_load       = 1'b0;
    pc_load_val   = 9'h000;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    test_reset();
    test_fetch();
    test_wrap();
    test_squash();
    test_halt();
    test_clr_mid_wait();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
